// File: rtl/bids22_controller_pkg.sv
// rtl/bids22_controller_pkg.sv - shared types for the BIDS22 bid controller
package BIDS22pkg;

   localparam int NUM_BIDDERS = 3;

   typedef enum logic [3:0] {
      OP_NOOP       = 4'd0,
      OP_UNLOCK     = 4'd1,
      OP_LOCK       = 4'd2,
      OP_LOAD_X     = 4'd3,
      OP_LOAD_Y     = 4'd4,
      OP_LOAD_Z     = 4'd5,
      OP_SET_MASK   = 4'd6,
      OP_SET_CHARGE = 4'd8
   } operation_t;

   typedef enum logic [1:0] {
      ST_UNLOCKED,
      ST_LOCKED,
      ST_ROUND_ACTIVE,
      ST_ROUND_OVER
   } state_t;

   typedef enum logic [1:0] {
      BERR_NONE           = 2'd0,
      BERR_ROUND_INACTIVE = 2'd1,
      BERR_INSUFFICIENT   = 2'd2,
      BERR_INVALID_REQ    = 2'd3
   } bidder_err_t;

   typedef enum logic [2:0] {
      CERR_NONE             = 3'd0,
      CERR_BAD_KEY          = 3'd1,
      CERR_ALREADY_UNLOCKED = 3'd2,
      CERR_ALREADY_LOCKED   = 3'd3,
      CERR_INVALID_OP       = 3'd4,
      CERR_LOCKED_WRITE     = 3'd5,
      CERR_START_UNLOCKED   = 3'd6
   } ctrl_err_t;

endpackage

// File: rtl/bids22_bidder_port.sv
// rtl/bids22_bidder_port.sv - per-bidder acceptance check for one bid request
module bids22_bidder_port
   import BIDS22pkg::*;
(
   input  logic [31:0] balance,
   input  logic [15:0] amt,
   input  logic        mask_bit,
   input  logic [31:0] charge,
   input  logic [15:0] max_bid,
   input  logic        active,
   output logic        accept,
   output bidder_err_t err
);

   logic [32:0] cost;

   // Cost is widened so a large charge cannot wrap and fake sufficient funds.
   always_comb begin
      cost   = {17'd0, amt} + {1'b0, charge};
      accept = 1'b0;
      err    = BERR_NONE;
      if (!active) begin
         err = BERR_ROUND_INACTIVE;
      end else if (!mask_bit || (amt <= max_bid)) begin
         err = BERR_INVALID_REQ;
      end else if ({1'b0, balance} < cost) begin
         err = BERR_INSUFFICIENT;
      end else begin
         accept = 1'b1;
      end
   end

endmodule

// File: rtl/bids22_controller.sv
// rtl/bids22_controller.sv - BIDS22 bid controller: lock/key, balances, sealed rounds
module bids22_controller
   import BIDS22pkg::*;
#(
   parameter logic [31:0] DEF_CHARGE = 32'd1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] X_bidAmt,
   input  logic [15:0] Y_bidAmt,
   input  logic [15:0] Z_bidAmt,
   input  logic        X_bid,
   input  logic        Y_bid,
   input  logic        Z_bid,
   input  logic        X_retract,
   input  logic        Y_retract,
   input  logic        Z_retract,
   input  logic [31:0] C_data,
   input  logic [3:0]  C_op,
   input  logic        C_start,
   output logic        X_ack,
   output logic        Y_ack,
   output logic        Z_ack,
   output logic [1:0]  X_err,
   output logic [1:0]  Y_err,
   output logic [1:0]  Z_err,
   output logic [31:0] X_balance,
   output logic [31:0] Y_balance,
   output logic [31:0] Z_balance,
   output logic        X_win,
   output logic        Y_win,
   output logic        Z_win,
   output logic        ready,
   output logic [2:0]  err,
   output logic        roundOver,
   output logic [31:0] maxBid
);

   state_t      state, state_nxt;
   logic [31:0] key_q, key_nxt, charge_q, charge_nxt;
   logic [2:0]  mask_q, mask_nxt, leader_q, leader_nxt;
   logic [15:0] max_bid_q, max_bid_nxt, amt [NUM_BIDDERS];
   logic [31:0] bal_q [NUM_BIDDERS];
   logic [31:0] bal_nxt [NUM_BIDDERS];
   logic [2:0]  bid_in, retract_in, accept, ack_q, ack_nxt, win_q, win_nxt, sel_oh;
   bidder_err_t port_err [NUM_BIDDERS];
   bidder_err_t berr_q [NUM_BIDDERS];
   bidder_err_t berr_nxt [NUM_BIDDERS];
   ctrl_err_t   cerr_q, cerr_nxt;
   logic        start_q, round_over_q, round_over_nxt, ready_nxt, round_run, op_valid, found;
   logic [15:0] best;

   assign amt[0]     = X_bidAmt;
   assign amt[1]     = Y_bidAmt;
   assign amt[2]     = Z_bidAmt;
   assign bid_in     = {Z_bid, Y_bid, X_bid};
   assign retract_in = {Z_retract, Y_retract, X_retract};
   // Bids count only while the round is still being held open.
   assign round_run  = (state == ST_ROUND_ACTIVE) && C_start;
   assign op_valid   = ready && !C_start;

   for (genvar g = 0; g < NUM_BIDDERS; g++) begin : g_port
      bids22_bidder_port u_port (
         .balance  (bal_q[g]),
         .amt      (amt[g]),
         .mask_bit (mask_q[g]),
         .charge   (charge_q),
         .max_bid  (max_bid_q),
         .active   (round_run),
         .accept   (accept[g]),
         .err      (port_err[g])
      );
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_UNLOCKED;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_UNLOCKED:     if (op_valid && C_op == OP_LOCK) state_nxt = ST_LOCKED;
         ST_LOCKED: begin
            if (C_start) state_nxt = ST_ROUND_ACTIVE;
            else if (op_valid && C_op == OP_UNLOCK && C_data == key_q) state_nxt = ST_UNLOCKED;
         end
         ST_ROUND_ACTIVE: if (!C_start) state_nxt = ST_ROUND_OVER;
         default:         state_nxt = ST_LOCKED;
      endcase
   end

   always_comb begin
      key_nxt = key_q;  charge_nxt = charge_q;  mask_nxt = mask_q;
      leader_nxt = leader_q;  max_bid_nxt = max_bid_q;
      cerr_nxt = CERR_NONE;  round_over_nxt = 1'b0;  win_nxt = '0;
      ack_nxt = '0;  found = 1'b0;  best = '0;  sel_oh = '0;
      for (int i = 0; i < NUM_BIDDERS; i++) begin
         bal_nxt[i]  = bal_q[i];
         berr_nxt[i] = BERR_NONE;
         if (bid_in[i]) begin
            if (accept[i]) begin
               ack_nxt[i] = 1'b1;
               bal_nxt[i] = bal_q[i] - charge_q;
               // Strict compare in X,Y,Z order gives X>Y>Z on equal amounts.
               if (!found || amt[i] > best) begin
                  found = 1'b1;  best = amt[i];  sel_oh = '0;  sel_oh[i] = 1'b1;
               end
            end else begin
               berr_nxt[i] = port_err[i];
            end
         end else if (retract_in[i]) begin
            if (!round_run)       berr_nxt[i] = BERR_ROUND_INACTIVE;
            else if (leader_q[i]) begin ack_nxt[i] = 1'b1; leader_nxt = '0; end
            else                  berr_nxt[i] = BERR_INVALID_REQ;
         end
      end
      if (found) begin
         leader_nxt  = sel_oh;
         max_bid_nxt = best;
      end

      case (state)
         ST_UNLOCKED: if (C_start && !start_q) cerr_nxt = CERR_START_UNLOCKED;
         ST_LOCKED:   if (C_start) begin max_bid_nxt = '0; leader_nxt = '0; end
         ST_ROUND_ACTIVE: if (!C_start) begin
            round_over_nxt = 1'b1;
            win_nxt        = leader_q;
            for (int i = 0; i < NUM_BIDDERS; i++)
               if (leader_q[i]) bal_nxt[i] = bal_q[i] - {16'd0, max_bid_q};
         end
         default: ;
      endcase

      if (op_valid) begin
         case (C_op)
            OP_NOOP: ;
            OP_UNLOCK: begin
               if (state == ST_UNLOCKED)  cerr_nxt = CERR_ALREADY_UNLOCKED;
               else if (C_data != key_q) cerr_nxt = CERR_BAD_KEY;
            end
            OP_LOCK: begin
               if (state == ST_LOCKED) cerr_nxt = CERR_ALREADY_LOCKED;
               else                    key_nxt  = C_data;
            end
            OP_LOAD_X, OP_LOAD_Y, OP_LOAD_Z, OP_SET_MASK, OP_SET_CHARGE: begin
               if (state == ST_LOCKED) cerr_nxt = CERR_LOCKED_WRITE;
               else begin
                  case (C_op)
                     OP_LOAD_X:   bal_nxt[0] = C_data;
                     OP_LOAD_Y:   bal_nxt[1] = C_data;
                     OP_LOAD_Z:   bal_nxt[2] = C_data;
                     OP_SET_MASK: mask_nxt   = C_data[2:0];
                     default:     charge_nxt = C_data;
                  endcase
               end
            end
            default: cerr_nxt = CERR_INVALID_OP;
         endcase
      end

      ready_nxt = (state_nxt == ST_UNLOCKED) || (state_nxt == ST_LOCKED);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         key_q <= '0;  charge_q <= DEF_CHARGE;  mask_q <= 3'b111;
         leader_q <= '0;  max_bid_q <= '0;  start_q <= 1'b0;
         cerr_q <= CERR_NONE;  round_over_q <= 1'b0;  win_q <= '0;
         ack_q <= '0;  ready <= 1'b1;
         for (int i = 0; i < NUM_BIDDERS; i++) begin
            bal_q[i]  <= '0;
            berr_q[i] <= BERR_NONE;
         end
      end else begin
         key_q <= key_nxt;  charge_q <= charge_nxt;  mask_q <= mask_nxt;
         leader_q <= leader_nxt;  max_bid_q <= max_bid_nxt;  start_q <= C_start;
         cerr_q <= cerr_nxt;  round_over_q <= round_over_nxt;  win_q <= win_nxt;
         ack_q <= ack_nxt;  ready <= ready_nxt;
         for (int i = 0; i < NUM_BIDDERS; i++) begin
            bal_q[i]  <= bal_nxt[i];
            berr_q[i] <= berr_nxt[i];
         end
      end
   end

   assign {Z_ack, Y_ack, X_ack} = ack_q;
   assign {Z_win, Y_win, X_win} = win_q;
   assign X_err     = berr_q[0];
   assign Y_err     = berr_q[1];
   assign Z_err     = berr_q[2];
   assign X_balance = bal_q[0];
   assign Y_balance = bal_q[1];
   assign Z_balance = bal_q[2];
   assign err       = cerr_q;
   assign roundOver = round_over_q;
   assign maxBid    = {16'd0, max_bid_q};

endmodule

// File: doc/bids22_controller.md
# bids22_controller

Bid controller, the responder to the BIDS22 stimulus interface: accepts controller operations (`C_op`/`C_data`/`C_start`) and bids/retractions from three bidders X, Y, Z. It maintains per-bidder balances, lock key, bid charge and bidder mask, and runs sealed rounds that each produce a winner and a `maxBid`. It is the DUT side of the BIDS22 testbench; all outputs are registered.

## Interface
Parameters:
- `DEF_CHARGE`, 1: reset value of the per-bid charge.

Ports:
- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `X_bidAmt`/`Y_bidAmt`/`Z_bidAmt`  in  16  bid amount, sampled with `_bid`
- `X_bid`/`Y_bid`/`Z_bid`  in  1  bid request, one cycle
- `X_retract`/`Y_retract`/`Z_retract`  in  1  retract request, one cycle
- `C_data`  in  32  operand for `C_op`
- `C_op`  in  4  controller operation (`operation_t`)
- `C_start`  in  1  high = round running
- `X_ack`/`Y_ack`/`Z_ack`  out  1  request accepted, one-cycle pulse
- `X_err`/`Y_err`/`Z_err`  out  2  bidder error code, one-cycle pulse
- `X_balance`/`Y_balance`/`Z_balance`  out  32  current balance
- `X_win`/`Y_win`/`Z_win`  out  1  winner flag, one cycle with `roundOver`
- `ready`  out  1  idle, accepting `C_op`
- `err`  out  3  controller error code, one-cycle pulse
- `roundOver`  out  1  round closed, one-cycle pulse
- `maxBid`  out  32  highest accepted bid (zero-extended)

## Operation
- States: UNLOCKED, LOCKED, ROUND_ACTIVE, ROUND_OVER.
- Reset values: state UNLOCKED; key 0; mask 3'b111; charge `DEF_CHARGE`; leader none; every output 0 except `ready`=1.
- `C_op` is decoded only when `ready`=1 and `C_start`=0. Codes:
  - 0 NoOp.
  - 1 Unlock: if `C_data`==key, go UNLOCKED; otherwise `err`=1 BadKey. If already UNLOCKED, `err`=2.
  - 2 Lock: key<=`C_data`, go LOCKED. If already LOCKED, `err`=3.
  - 3/4/5 LoadX/Y/Z: balance<=`C_data`.
  - 6 SetMask: mask<=`C_data[2:0]`.
  - 8 SetCharge: charge<=`C_data`.
  - Ops 3..8 issued while LOCKED give `err`=5 and change no state.
  - Codes 7 and 9..15 give `err`=4 InvalidOp.
- Round start: `C_start` high in LOCKED goes to ROUND_ACTIVE, clears `maxBid` and leader, drops `ready`. `C_start` high in UNLOCKED gives `err`=6 once per assertion.
- Bid check in ROUND_ACTIVE, per bidder, against last cycle's `maxBid`. A bid is accepted only if all hold:
  - bidder is in mask;
  - amt > `maxBid`;
  - balance >= amt + charge.
- Bid errors: masked or amt <= `maxBid` gives err 3; insufficient funds gives err 2. A bid or retract outside ROUND_ACTIVE gives err 1.
- Accepted bid: `_ack`=1, balance -= charge. New leader is the highest accepted amt, ties broken X>Y>Z. `maxBid`<=that amt.
- Retract:
  - by the current leader: ack, leader cleared, `maxBid` unchanged;
  - by a non-leader: err 3.
  - Bid and retract from the same bidder in the same cycle: the bid wins and the retract is ignored.
- Round close: `C_start` falling in ROUND_ACTIVE goes to ROUND_OVER for exactly one cycle.
  - `roundOver`=1.
  - If a leader exists: leader `_win`=1 and leader balance -= `maxBid`.
  - Next state is LOCKED and `ready`=1.
  - Balance never underflows: the accept rule guarantees balance >= `maxBid`.
- Arithmetic: 32-bit unsigned; amt + charge is computed in 33 bits.

## Timing
- All outputs are registered. Responses (ack, err, state change, balance update) appear the cycle after the sampling edge.
- ack/err pulses last exactly one cycle. Balances and `maxBid` hold until changed.
- `roundOver` and `_win` rise one cycle after `C_start` is sampled low.
- `reset_n` low asserts immediately, mid-round included: state UNLOCKED, balances 0, no `roundOver`.

## Structure
- `BIDS22pkg` holds:
  - `operation_t` (4-bit codes above);
  - `state_t`;
  - `bidder_err_t`: 0 none, 1 RoundInactive, 2 Insufficient, 3 InvalidReq;
  - `ctrl_err_t`: 0 none, 1 BadKey, 2 AlreadyUnlocked, 3 AlreadyLocked, 4 InvalidOp, 5 LockedWrite, 6 StartUnlocked.
- One sub-module, `bids22_bidder_port`, instantiated three times. Inputs: balance, amt, mask bit, charge, maxBid, active. Outputs: accept and err. The arbitration for leader selection lives in the top.

## Test plan
- Reset, then LoadX 100 → `X_balance`=100. Lock key 0x55 → `ready`=1. LoadY 5 → `err`=5 pulse and `Y_balance` unchanged.
- Unlock with 0x54 → `err`=1. Unlock with 0x55 → UNLOCKED and `err`=0.
- Balances X=100, Y=50, charge 1, locked. `C_start`=1. X bids 20 → `X_ack`, `X_balance`=99, `maxBid`=20. Y bids 20 → `Y_err`=3. `C_start`=0 → `roundOver` pulse, `X_win`=1, `X_balance`=79.
- Same-cycle X bid 30 and Z bid 30, both funded → both acked and both charged; leader X; `maxBid`=30.
- Y balance 10, charge 1, Y bids 10 → `Y_err`=2. X leads, X retracts → `X_ack`, round closes with all `_win`=0.
- Mid-round `reset_n` low → all outputs 0 except `ready`=1; bid afterwards → `_err`=1.
